// File: rtl/jtagbuf_pkg.sv
// Shared state encoding and error-counter constants for the JTAG buffer self-test.
package jtagbuf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_SAT = 8'd255;

  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] cnt);
    logic [ERR_W-1:0] res;
    if (cnt == ERR_SAT) begin
      res = cnt;
    end else begin
      res = cnt + ERR_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/jtagbuf_if.sv
// Host/target buffer lanes and self-test control/status bundle.
// FAIL_MAP exists only when JTAGBUF_FAILMAP_EN is defined.
interface jtagbuf_if #(parameter int N_CH = 8);
  import jtagbuf_pkg::*;

  localparam int CH_W = $clog2(N_CH);

  logic              TEST_START;
  logic              FT_OE_N;
  logic [N_CH-1:0]   FT_OUT;
  logic [N_CH-1:0]   TGT_OUT;
  logic [N_CH-1:0]   TGT_OE;
  logic [N_CH-1:0]   TGT_IN;
  logic [N_CH-1:0]   FT_IN;
  logic              TEST_BUSY;
  logic              TEST_DONE;
  logic              TEST_PASS;
  logic [CH_W-1:0]   FAIL_CH;
  logic [ERR_W-1:0]  ERR_CNT;

`ifdef JTAGBUF_FAILMAP_EN
  logic [N_CH-1:0]   FAIL_MAP;

  modport slave (
    input  TEST_START, FT_OE_N, FT_OUT, TGT_IN,
    output TGT_OUT, TGT_OE, FT_IN, TEST_BUSY, TEST_DONE, TEST_PASS, FAIL_CH, ERR_CNT, FAIL_MAP
  );
  modport master (
    output TEST_START, FT_OE_N, FT_OUT, TGT_IN,
    input  TGT_OUT, TGT_OE, FT_IN, TEST_BUSY, TEST_DONE, TEST_PASS, FAIL_CH, ERR_CNT, FAIL_MAP
  );
`else
  modport slave (
    input  TEST_START, FT_OE_N, FT_OUT, TGT_IN,
    output TGT_OUT, TGT_OE, FT_IN, TEST_BUSY, TEST_DONE, TEST_PASS, FAIL_CH, ERR_CNT
  );
  modport master (
    output TEST_START, FT_OE_N, FT_OUT, TGT_IN,
    input  TGT_OUT, TGT_OE, FT_IN, TEST_BUSY, TEST_DONE, TEST_PASS, FAIL_CH, ERR_CNT
  );
`endif

endinterface

// File: rtl/jtagbuf_pattern_gen.sv
// Walking-one / walking-zero test pattern for vector index v (0..2*N_CH-1).
module jtagbuf_pattern_gen #(
  parameter int N_CH = 8,
  parameter int V_W  = $clog2(2 * N_CH)
) (
  input  logic [V_W-1:0]  v,
  output logic [N_CH-1:0] pattern
);

  logic           walk_zero_s;
  logic [V_W-1:0] idx_s;

  // Upper half of the index range selects the inverted (walking-zero) pattern.
  always_comb begin
    walk_zero_s = (v >= V_W'(N_CH));
    if (walk_zero_s) begin
      idx_s = v - V_W'(N_CH);
    end else begin
      idx_s = v;
    end
    for (int i = 0; i < N_CH; i++) begin
      pattern[i] = (idx_s == V_W'(i)) ^ walk_zero_s;
    end
  end

endmodule

// File: rtl/jtag_buffer_selftest.sv
// JTAG level-shifter buffer with built-in walking-one/zero loopback self-test.
// Define JTAGBUF_FAILMAP_EN to add the accumulated per-channel FAIL_MAP output.
module jtag_buffer_selftest
  import jtagbuf_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int SETTLE = 4
) (
  input  logic     CLK,
  input  logic     RST,
  jtagbuf_if.slave bus
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int V_W   = $clog2(2 * N_CH);
  localparam int CNT_W = $clog2(SETTLE + 1);

  state_e            state_r, state_n;
  logic [V_W-1:0]    v_r, v_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic [ERR_W-1:0]  err_cnt_r, err_cnt_n;
  logic [CH_W-1:0]   fail_ch_r, fail_ch_n;
  logic              busy_r, done_r, pass_r;
  logic              run_s;
  logic [N_CH-1:0]   pattern_s, mismatch_s;
  logic [CH_W-1:0]   low_idx_s;
`ifdef JTAGBUF_FAILMAP_EN
  logic [N_CH-1:0]   fail_map_r, fail_map_n;
`endif

  jtagbuf_pattern_gen #(.N_CH(N_CH), .V_W(V_W)) u_pattern (
    .v       (v_r),
    .pattern (pattern_s)
  );

  assign run_s      = (state_r == ST_DRIVE) || (state_r == ST_SETTLE) || (state_r == ST_SAMPLE);
  assign mismatch_s = bus.TGT_IN ^ pattern_s;

  // Lowest mismatching channel: scan from the top so the lowest hit wins.
  always_comb begin
    low_idx_s = {CH_W{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mismatch_s[i]) begin
        low_idx_s = CH_W'(i);
      end else begin
        low_idx_s = low_idx_s;
      end
    end
  end

  // Next-state and result bookkeeping; err_cnt_r == 0 marks "no failing vector yet".
  always_comb begin
    state_n   = state_r;
    v_n       = v_r;
    cnt_n     = cnt_r;
    err_cnt_n = err_cnt_r;
    fail_ch_n = fail_ch_r;
`ifdef JTAGBUF_FAILMAP_EN
    fail_map_n = fail_map_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.TEST_START) begin
          state_n   = ST_DRIVE;
          v_n       = {V_W{1'b0}};
          err_cnt_n = {ERR_W{1'b0}};
          fail_ch_n = {CH_W{1'b0}};
`ifdef JTAGBUF_FAILMAP_EN
          fail_map_n = {N_CH{1'b0}};
`endif
        end else begin
          state_n = state_r;
        end
      end
      ST_DRIVE: begin
        state_n = ST_SETTLE;
        cnt_n   = {CNT_W{1'b0}};
      end
      ST_SETTLE: begin
        if (cnt_r == CNT_W'(SETTLE - 1)) begin
          state_n = ST_SAMPLE;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (mismatch_s != {N_CH{1'b0}}) begin
          err_cnt_n = err_inc(err_cnt_r);
`ifdef JTAGBUF_FAILMAP_EN
          fail_map_n = fail_map_r | mismatch_s;
`endif
          if (err_cnt_r == {ERR_W{1'b0}}) begin
            fail_ch_n = low_idx_s;
          end else begin
            fail_ch_n = fail_ch_r;
          end
        end else begin
          err_cnt_n = err_cnt_r;
        end
        if (v_r == V_W'(2 * N_CH - 1)) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_DRIVE;
          v_n     = v_r + V_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and status registers; RST overrides any simultaneous start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      v_r       <= {V_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      err_cnt_r <= {ERR_W{1'b0}};
      fail_ch_r <= {CH_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
`ifdef JTAGBUF_FAILMAP_EN
      fail_map_r <= {N_CH{1'b0}};
`endif
    end else begin
      state_r   <= state_n;
      v_r       <= v_n;
      cnt_r     <= cnt_n;
      err_cnt_r <= err_cnt_n;
      fail_ch_r <= fail_ch_n;
      busy_r    <= (state_n == ST_DRIVE) || (state_n == ST_SETTLE) || (state_n == ST_SAMPLE);
      done_r    <= (state_n == ST_DONE);
      pass_r    <= (state_n == ST_DONE) && (err_cnt_n == {ERR_W{1'b0}});
`ifdef JTAGBUF_FAILMAP_EN
      fail_map_r <= fail_map_n;
`endif
    end
  end

  // Buffer lanes: test pattern during a run, transparent pass-through otherwise.
  always_comb begin
    if (run_s) begin
      bus.TGT_OUT = pattern_s;
      bus.TGT_OE  = {N_CH{1'b1}};
      bus.FT_IN   = {N_CH{1'b0}};
    end else begin
      bus.TGT_OUT = bus.FT_OUT;
      bus.TGT_OE  = {N_CH{~bus.FT_OE_N}};
      bus.FT_IN   = bus.TGT_IN;
    end
  end

  assign bus.TEST_BUSY = busy_r;
  assign bus.TEST_DONE = done_r;
  assign bus.TEST_PASS = pass_r;
  assign bus.FAIL_CH   = fail_ch_r;
  assign bus.ERR_CNT   = err_cnt_r;
`ifdef JTAGBUF_FAILMAP_EN
  assign bus.FAIL_MAP  = fail_map_r;
`endif

endmodule

// File: tb/tb_jtag_buffer_selftest.sv
// Self-checking bench: cycle-level behavioural model for an 8-channel DUT plus a 16-channel run.
module tb_jtag_buffer_selftest;

  localparam int N   = 8;
  localparam int S   = 4;
  localparam int N2  = 16;
  localparam int RUN = 1 + 2 * N * (S + 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtagbuf_if #(.N_CH(N))  bus8 ();
  jtagbuf_if #(.N_CH(N2)) bus16 ();

  jtag_buffer_selftest #(.N_CH(N), .SETTLE(S)) dut8 (
    .CLK (clk),
    .RST (rst),
    .bus (bus8.slave)
  );

  jtag_buffer_selftest #(.N_CH(N2), .SETTLE(S)) dut16 (
    .CLK (clk),
    .RST (rst),
    .bus (bus16.slave)
  );

  // Test fixture: loopback with optional stuck-at faults, or a fixed receive value.
  logic       loop_en;
  logic [7:0] s0_mask, s1_mask, fixed_in;
  assign bus8.TGT_IN = loop_en ? ((bus8.TGT_OUT & ~s0_mask) | s1_mask) : fixed_in;
  assign bus16.TGT_IN  = 16'h0000;
  assign bus16.FT_OUT  = 16'h0000;
  assign bus16.FT_OE_N = 1'b1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat8(input int v);
    logic [7:0] one;
    one = 8'd1 << (v % N);
    return (v < N) ? one : ~one;
  endfunction

  function automatic logic [7:0] fixture(input logic [7:0] drive);
    return loop_en ? ((drive & ~s0_mask) | s1_mask) : fixed_in;
  endfunction

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < N; i++) begin
      if (m[i]) return i;
    end
    return 0;
  endfunction

  // Model: run cycle k counts from the start cycle (k=0); vector v occupies cycles
  // 1+v*(S+2) .. (v+1)*(S+2), its sample is the last of those, DONE shows at k=RUN.
  bit         m_active = 1'b0, m_done = 1'b0, m_pass = 1'b0;
  int         m_k = 0, m_err = 0, m_failch = 0;
  logic [7:0] m_map = 8'h00;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 1'b0; m_done = 1'b0; m_pass = 1'b0;
        m_k = 0; m_err = 0; m_failch = 0; m_map = 8'h00;
      end else if (m_active) begin
        if ((m_k - 1) % (S + 2) == S + 1) begin
          int v;
          logic [7:0] mism;
          v    = (m_k - 1) / (S + 2);
          mism = fixture(pat8(v)) ^ pat8(v);
          if (mism != 8'h00) begin
            if (m_err == 0) m_failch = lowest(mism);
            if (m_err < 255) m_err++;
            m_map = m_map | mism;
          end
        end
        m_k++;
        if (m_k == RUN) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_pass   = (m_err == 0);
        end
      end else if (bus8.TEST_START) begin
        m_active = 1'b1; m_k = 1; m_err = 0; m_failch = 0; m_map = 8'h00;
        m_done = 1'b0; m_pass = 1'b0;
      end
    end
  end

  // Every-cycle comparison of the 8-channel DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        logic [7:0] e_out, e_oe, e_in;
        if (m_active) begin
          e_out = pat8((m_k - 1) / (S + 2));
          e_oe  = 8'hFF;
          e_in  = 8'h00;
        end else begin
          e_out = bus8.FT_OUT;
          e_oe  = {8{~bus8.FT_OE_N}};
          e_in  = fixture(e_out);
        end
        chk("tgt_out", bus8.TGT_OUT, e_out);
        chk("tgt_oe", bus8.TGT_OE, e_oe);
        chk("ft_in", bus8.FT_IN, e_in);
        chk("busy", bus8.TEST_BUSY, m_active);
        chk("done", bus8.TEST_DONE, m_done);
        chk("pass", bus8.TEST_PASS, m_pass);
        chk("err_cnt", bus8.ERR_CNT, m_err);
        chk("fail_ch", bus8.FAIL_CH, m_failch);
`ifdef JTAGBUF_FAILMAP_EN
        chk("fail_map", bus8.FAIL_MAP, m_map);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Start a run on the 8-channel DUT; report the cycle TEST_DONE rises (-1 on timeout).
  task automatic run8(input int repulse_at, output int done_cyc, output logic busy1, output logic done1);
    int cyc = 0;
    done_cyc = -1;
    busy1 = 1'b0;
    done1 = 1'b1;
    bus8.TEST_START = 1'b1;
    while (cyc < 400 && done_cyc < 0) begin
      tick();
      cyc++;
      bus8.TEST_START = (cyc == repulse_at);
      if (cyc == 1) begin
        busy1 = bus8.TEST_BUSY;
        done1 = bus8.TEST_DONE;
      end else if (bus8.TEST_DONE === 1'b1) begin
        done_cyc = cyc;
      end
    end
    bus8.TEST_START = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   dc;
    logic b1, d1;

    rst = 1'b1;
    bus8.TEST_START = 1'b0; bus8.FT_OE_N = 1'b1; bus8.FT_OUT = 8'h00;
    bus16.TEST_START = 1'b0;
    loop_en = 1'b1; s0_mask = 8'h00; s1_mask = 8'h00; fixed_in = 8'h00;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", bus8.TEST_BUSY, 1'b0);
    chk("rst_done", bus8.TEST_DONE, 1'b0);
    chk("rst_pass", bus8.TEST_PASS, 1'b0);
    chk("rst_err", bus8.ERR_CNT, 8'd0);
    chk("rst_fail_ch", bus8.FAIL_CH, 3'd0);

    // Clean loopback.
    run8(0, dc, b1, d1);
    chk("clean_done_cycle", dc, 97);
    chk("clean_busy_c1", b1, 1'b1);
    chk("clean_err", bus8.ERR_CNT, 8'd0);
    chk("clean_pass", bus8.TEST_PASS, 1'b1);
    chk("clean_busy_end", bus8.TEST_BUSY, 1'b0);

    // TGT_IN[3] stuck at 0, started from DONE.
    s0_mask = 8'h08;
    run8(0, dc, b1, d1);
    chk("rerun_done_cleared", d1, 1'b0);
    chk("stuck3_done_cycle", dc, 97);
    chk("stuck3_err", bus8.ERR_CNT, 8'd8);
    chk("stuck3_fail_ch", bus8.FAIL_CH, 3'd3);
    chk("stuck3_pass", bus8.TEST_PASS, 1'b0);
`ifdef JTAGBUF_FAILMAP_EN
    chk("stuck3_fail_map", bus8.FAIL_MAP, 8'h08);
`endif

    // Pass-through.
    loop_en = 1'b0; fixed_in = 8'h3C; bus8.FT_OE_N = 1'b0; bus8.FT_OUT = 8'hA5;
    tick();
    chk("pt_tgt_out", bus8.TGT_OUT, 8'hA5);
    chk("pt_tgt_oe", bus8.TGT_OE, 8'hFF);
    chk("pt_ft_in", bus8.FT_IN, 8'h3C);
    bus8.FT_OE_N = 1'b1;
    tick();
    chk("pt_tgt_oe_off", bus8.TGT_OE, 8'h00);

    // Start re-pulsed mid-run is ignored.
    loop_en = 1'b1; s0_mask = 8'h00;
    run8(30, dc, b1, d1);
    chk("repulse_done_cycle", dc, 97);
    chk("repulse_pass", bus8.TEST_PASS, 1'b1);

    // Reset at run cycle 20 with channel 0 stuck low.
    s0_mask = 8'h01; bus8.FT_OE_N = 1'b0; bus8.FT_OUT = 8'h5A;
    bus8.TEST_START = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus8.TEST_START = 1'b0;
      if (c == 19) chk("midrun_err_c19", bus8.ERR_CNT, 8'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", bus8.TEST_BUSY, 1'b0);
    chk("abort_err", bus8.ERR_CNT, 8'd0);
    chk("abort_done", bus8.TEST_DONE, 1'b0);
    chk("abort_pt_out", bus8.TGT_OUT, 8'h5A);
    chk("abort_pt_oe", bus8.TGT_OE, 8'hFF);

    // RST wins over a simultaneous start.
    rst = 1'b1; bus8.TEST_START = 1'b1;
    tick();
    rst = 1'b0; bus8.TEST_START = 1'b0;
    chk("rst_prio_busy", bus8.TEST_BUSY, 1'b0);
    tick();
    chk("rst_prio_busy_next", bus8.TEST_BUSY, 1'b0);

    // 16 channels, receive tied low: every walking-one and walking-zero vector fails.
    bus16.TEST_START = 1'b1;
    dc = -1;
    for (int c = 1; c <= 400 && dc < 0; c++) begin
      tick();
      bus16.TEST_START = 1'b0;
      if (bus16.TEST_DONE === 1'b1) dc = c;
    end
    chk("n16_done_cycle", dc, 1 + 2 * N2 * (S + 2));
    chk("n16_err", bus16.ERR_CNT, 8'd32);
    chk("n16_fail_ch", bus16.FAIL_CH, 4'd0);
    chk("n16_pass", bus16.TEST_PASS, 1'b0);
`ifdef JTAGBUF_FAILMAP_EN
    chk("n16_fail_map", bus16.FAIL_MAP, 16'hFFFF);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
